// File: rtl/edf_sched_ctrl.sv
// Two-task / two-processor earliest-deadline-first dispatcher: per-task deadline queues,
// per-slot busy counters, and registered one-cycle dispatch pulses.
module edf_sched_ctrl #(
  parameter int WCET_A = 2,
  parameter int WCET_B = 3,
  parameter int DL_A   = 5,
  parameter int DL_B   = 7,
  parameter int QDEPTH = 2,
  parameter int CW     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         startA,
  input  logic                         startB,
  input  logic                         tick,
  output logic                         sched0,
  output logic                         sched1,
  output logic                         sel0,
  output logic                         sel1,
  output logic                         busy0,
  output logic                         busy1,
  output logic [$clog2(QDEPTH+1)-1:0]  pendA,
  output logic [$clog2(QDEPTH+1)-1:0]  pendB,
  output logic                         miss,
  output logic                         ovf
);

  localparam int PW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DL_C   [2] = '{CW'(DL_A), CW'(DL_B)};
  localparam logic [CW-1:0] WCET_C [2] = '{CW'(WCET_A), CW'(WCET_B)};

  // Index 0 = task A, 1 = task B; queue entry 0 is the head.
  logic [CW-1:0] q_q     [2][QDEPTH];
  logic [CW-1:0] q_d     [2][QDEPTH];
  logic [PW-1:0] cnt_q   [2];
  logic [PW-1:0] cnt_d   [2];
  logic [CW-1:0] bcnt_q  [2];
  logic [CW-1:0] bcnt_d  [2];
  logic [1:0]    sched_q, sched_d;
  logic [1:0]    sel_q, sel_d;
  logic          miss_q, miss_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    start_v;
  logic [1:0]    head_v, sec_v, free_v, drop_v, push_ok;
  logic [CW-1:0] head_dl [2];
  logic [CW-1:0] sec_dl  [2];
  logic [1:0]    pop     [2];
  logic [PW-1:0] rem     [2];
  logic          zero_v  [2][QDEPTH];

  logic          fp_v, fp_sel, oh_v, ss_v, sp_v, sp_sel;
  logic [CW-1:0] oh_dl, ss_dl;

  assign start_v = {startB, startA};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cand
    assign head_v[gi]  = (cnt_q[gi] != '0);
    assign sec_v[gi]   = (cnt_q[gi] > PW'(1));
    assign head_dl[gi] = q_q[gi][0];
    if (QDEPTH > 1) begin : g_sec
      assign sec_dl[gi] = q_q[gi][1];
    end else begin : g_nosec
      assign sec_dl[gi] = '0;
    end
    assign free_v[gi] = (bcnt_q[gi] == '0);
  end

  // First pick: earliest head, B only when strictly earlier than A.
  assign fp_v   = head_v[0] | head_v[1];
  assign fp_sel = ~head_v[0] | (head_v[1] & (head_dl[1] < head_dl[0]));

  // Second pick: other task's head vs. the picked task's second entry.
  assign oh_v  = fp_sel ? head_v[0]  : head_v[1];
  assign oh_dl = fp_sel ? head_dl[0] : head_dl[1];
  assign ss_v  = fp_sel ? sec_v[1]   : sec_v[0];
  assign ss_dl = fp_sel ? sec_dl[1]  : sec_dl[0];
  assign sp_v  = fp_v & (oh_v | ss_v);

  always_comb begin
    sp_sel = ~fp_sel;
    if (!ss_v) begin
      sp_sel = ~fp_sel;
    end else if (!oh_v) begin
      sp_sel = fp_sel;
    end else if (oh_dl == ss_dl) begin
      sp_sel = 1'b0;
    end else if (oh_dl < ss_dl) begin
      sp_sel = ~fp_sel;
    end else begin
      sp_sel = fp_sel;
    end
  end

  always_comb begin
    sched_d = '0;
    sel_d   = '0;
    if (free_v[0] && fp_v) begin
      sched_d[0] = 1'b1;
      sel_d[0]   = fp_sel;
      if (free_v[1] && sp_v) begin
        sched_d[1] = 1'b1;
        sel_d[1]   = sp_sel;
      end
    end else if (free_v[1] && fp_v) begin
      sched_d[1] = 1'b1;
      sel_d[1]   = fp_sel;
    end
  end

  for (genvar gk = 0; gk < 2; gk++) begin : g_slot
    assign bcnt_d[gk] = sched_d[gk]                   ? WCET_C[sel_d[gk]] :
                        (tick && bcnt_q[gk] != '0)    ? bcnt_q[gk] - CW'(1) :
                                                        bcnt_q[gk];
  end

  for (genvar gt = 0; gt < 2; gt++) begin : g_task
    assign pop[gt] = 2'(sched_d[0] && (sel_d[0] == 1'(gt)))
                   + 2'(sched_d[1] && (sel_d[1] == 1'(gt)));
    assign rem[gt]     = cnt_q[gt] - PW'(pop[gt]);
    assign drop_v[gt]  = start_v[gt] && (rem[gt] == PW'(QDEPTH));
    assign push_ok[gt] = start_v[gt] && (rem[gt] != PW'(QDEPTH));
    assign cnt_d[gt]   = push_ok[gt] ? rem[gt] + PW'(1) : rem[gt];

    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_ent
      logic [CW-1:0] nxt1, nxt2, shifted, aged;
      logic          live;
      if (gi + 1 < QDEPTH) begin : g_n1
        assign nxt1 = q_q[gt][gi+1];
      end else begin : g_n1z
        assign nxt1 = '0;
      end
      if (gi + 2 < QDEPTH) begin : g_n2
        assign nxt2 = q_q[gt][gi+2];
      end else begin : g_n2z
        assign nxt2 = '0;
      end
      assign shifted = (pop[gt] == 2'd2) ? nxt2 : (pop[gt] == 2'd1) ? nxt1 : q_q[gt][gi];
      assign aged    = (tick && shifted != '0) ? shifted - CW'(1) : shifted;
      assign live    = (PW'(gi) < rem[gt]);
      // A fresh push lands just behind the surviving entries and is not aged this cycle.
      assign q_d[gt][gi]    = (push_ok[gt] && PW'(gi) == rem[gt]) ? DL_C[gt] :
                              live ? aged : '0;
      assign zero_v[gt][gi] = live && (aged == '0);
    end
  end

  always_comb begin
    miss_d = miss_q;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < QDEPTH; i++) begin
        miss_d = miss_d | zero_v[t][i];
      end
    end
  end

  assign ovf_d = ovf_q | (|drop_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '{default: '0};
      cnt_q   <= '{default: '0};
      bcnt_q  <= '{default: '0};
      sched_q <= '0;
      sel_q   <= '0;
      miss_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sched_q <= sched_d;
      sel_q   <= sel_d;
      miss_q  <= miss_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sched0 = sched_q[0];
  assign sched1 = sched_q[1];
  assign sel0   = sel_q[0];
  assign sel1   = sel_q[1];
  assign busy0  = (bcnt_q[0] != '0);
  assign busy1  = (bcnt_q[1] != '0);
  assign pendA  = cnt_q[0];
  assign pendB  = cnt_q[1];
  assign miss   = miss_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_edf_sched_ctrl.sv
// Bench for edf_sched_ctrl: four parameter variants share one stimulus stream; dispatch
// pulses of the default variant are matched against a queue of expected (slot, task) records.
module tb_edf_sched_ctrl;

  localparam int NI    = 4;
  localparam int I_DEF = 0;
  localparam int I_B5  = 1;
  localparam int I_B4  = 2;
  localparam int I_W8  = 3;
  localparam int DLB_P [NI] = '{7, 5, 4, 7};
  localparam int WCA_P [NI] = '{2, 2, 2, 8};

  logic clk = 1'b0;
  logic rst, startA, startB, tick;

  logic       sched0_w [NI];
  logic       sched1_w [NI];
  logic       sel0_w   [NI];
  logic       sel1_w   [NI];
  logic       busy0_w  [NI];
  logic       busy1_w  [NI];
  logic [1:0] pendA_w  [NI];
  logic [1:0] pendB_w  [NI];
  logic       miss_w   [NI];
  logic       ovf_w    [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    edf_sched_ctrl #(
      .WCET_A(WCA_P[gi]),
      .WCET_B(3),
      .DL_A  (5),
      .DL_B  (DLB_P[gi]),
      .QDEPTH(2),
      .CW    (4)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .startA(startA),
      .startB(startB),
      .tick  (tick),
      .sched0(sched0_w[gi]),
      .sched1(sched1_w[gi]),
      .sel0  (sel0_w[gi]),
      .sel1  (sel1_w[gi]),
      .busy0 (busy0_w[gi]),
      .busy1 (busy1_w[gi]),
      .pendA (pendA_w[gi]),
      .pendB (pendB_w[gi]),
      .miss  (miss_w[gi]),
      .ovf   (ovf_w[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic slot;
    logic sel;
  } exp_t;
  exp_t sb_q[$];

  task automatic sb_push(input logic slot, input logic sel);
    exp_t e;
    e.slot = slot;
    e.sel  = sel;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic slot, input logic sel);
    exp_t e;
    $display("t=%0t dispatch slot=%0d task=%s", $time, slot, sel ? "B" : "A");
    check_eq("sb_has_entry", (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("sb_slot", slot, e.slot);
      check_eq("sb_sel", sel, e.sel);
    end
  endtask

  always @(negedge clk) begin
    if (sched0_w[I_DEF] === 1'b1) sb_pop(1'b0, sel0_w[I_DEF]);
    if (sched1_w[I_DEF] === 1'b1) sb_pop(1'b1, sel1_w[I_DEF]);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input int k);
    check_eq({tag, "_sched0"}, sched0_w[k], 0);
    check_eq({tag, "_sched1"}, sched1_w[k], 0);
    check_eq({tag, "_sel0"},   sel0_w[k],   0);
    check_eq({tag, "_sel1"},   sel1_w[k],   0);
    check_eq({tag, "_busy0"},  busy0_w[k],  0);
    check_eq({tag, "_busy1"},  busy1_w[k],  0);
    check_eq({tag, "_pendA"},  pendA_w[k],  0);
    check_eq({tag, "_pendB"},  pendB_w[k],  0);
    check_eq({tag, "_miss"},   miss_w[k],   0);
    check_eq({tag, "_ovf"},    ovf_w[k],    0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; startA = 1'b0; startB = 1'b0; tick = 1'b0;

    // Reset held two cycles with random inputs
    repeat (2) begin
      startA = 1'($urandom_range(0, 1));
      startB = 1'($urandom_range(0, 1));
      tick   = 1'($urandom_range(0, 1));
      step();
      for (int k = 0; k < NI; k++) check_idle("rst", k);
    end
    rst = 1'b0; startA = 1'b0; startB = 1'b0; tick = 1'b0;
    step();

    // Single A job: latency, busy, release after WCET_A ticks
    startA = 1'b1; sb_push(1'b0, 1'b0);
    step();
    check_eq("a1_pendA_e0", pendA_w[I_DEF], 1);
    check_eq("a1_sched0_e0", sched0_w[I_DEF], 0);
    startA = 1'b0;
    step();
    check_eq("a1_sched0_e1", sched0_w[I_DEF], 1);
    check_eq("a1_sel0_e1", sel0_w[I_DEF], 0);
    check_eq("a1_sched1_e1", sched1_w[I_DEF], 0);
    check_eq("a1_busy0_e1", busy0_w[I_DEF], 1);
    check_eq("a1_pendA_e1", pendA_w[I_DEF], 0);
    tick = 1'b1;
    step();
    check_eq("a1_sched0_pulse_len", sched0_w[I_DEF], 0);
    check_eq("a1_busy0_tick1", busy0_w[I_DEF], 1);
    step();
    check_eq("a1_busy0_tick2", busy0_w[I_DEF], 0);
    tick = 1'b0;

    // A+B together: dual dispatch; deadline tie/override variants
    startA = 1'b1; startB = 1'b1;
    sb_push(1'b0, 1'b0); sb_push(1'b1, 1'b1);
    step();
    check_eq("ab_pendA", pendA_w[I_DEF], 1);
    check_eq("ab_pendB", pendB_w[I_DEF], 1);
    startA = 1'b0; startB = 1'b0;
    step();
    check_eq("ab_sched0", sched0_w[I_DEF], 1);
    check_eq("ab_sched1", sched1_w[I_DEF], 1);
    check_eq("ab_sel0", sel0_w[I_DEF], 0);
    check_eq("ab_sel1", sel1_w[I_DEF], 1);
    check_eq("ab_pendA_after", pendA_w[I_DEF], 0);
    check_eq("ab_pendB_after", pendB_w[I_DEF], 0);
    check_eq("b5_sched0", sched0_w[I_B5], 1);
    check_eq("b5_sched1", sched1_w[I_B5], 1);
    check_eq("b5_tie_sel0", sel0_w[I_B5], 0);
    check_eq("b5_tie_sel1", sel1_w[I_B5], 1);
    check_eq("b4_sel0", sel0_w[I_B4], 1);
    check_eq("b4_sel1", sel1_w[I_B4], 0);

    // Both slots stay busy without ticks: queue fills, third release overflows
    startA = 1'b1;
    step();
    check_eq("of_busy0", busy0_w[I_DEF], 1);
    check_eq("of_busy1", busy1_w[I_DEF], 1);
    check_eq("of_pendA_1", pendA_w[I_DEF], 1);
    step();
    check_eq("of_pendA_2", pendA_w[I_DEF], 2);
    check_eq("of_ovf_2", ovf_w[I_DEF], 0);
    step();
    check_eq("of_pendA_3", pendA_w[I_DEF], 2);
    check_eq("of_ovf_3", ovf_w[I_DEF], 1);
    check_eq("of_sched0", sched0_w[I_DEF], 0);
    check_eq("of_sched1", sched1_w[I_DEF], 0);

    // Reset wins over simultaneous releases and tick
    rst = 1'b1; startA = 1'b1; startB = 1'b1; tick = 1'b1;
    step();
    check_idle("midrst", I_DEF);
    rst = 1'b0; startA = 1'b0; startB = 1'b0; tick = 1'b0;
    step();
    check_eq("postrst_sched0", sched0_w[I_DEF], 0);
    check_eq("postrst_sched1", sched1_w[I_DEF], 0);
    check_eq("postrst_pendA", pendA_w[I_DEF], 0);

    // Long WCET_A: both slots taken, third job waits and misses its deadline
    startA = 1'b1; sb_push(1'b0, 1'b0);
    step();
    check_eq("w8_pendA_e0", pendA_w[I_W8], 1);
    sb_push(1'b1, 1'b0);
    step();
    check_eq("w8_sched0_e1", sched0_w[I_W8], 1);
    check_eq("w8_pendA_e1", pendA_w[I_W8], 1);
    sb_push(1'b0, 1'b0);
    step();
    check_eq("w8_sched1_e2", sched1_w[I_W8], 1);
    check_eq("w8_sel1_e2", sel1_w[I_W8], 0);
    check_eq("w8_busy0", busy0_w[I_W8], 1);
    check_eq("w8_busy1", busy1_w[I_W8], 1);
    check_eq("w8_pendA_e2", pendA_w[I_W8], 1);
    startA = 1'b0; tick = 1'b1;
    repeat (4) step();
    check_eq("w8_miss_tick4", miss_w[I_W8], 0);
    check_eq("w8_busy0_tick4", busy0_w[I_W8], 1);
    step();
    check_eq("w8_miss_tick5", miss_w[I_W8], 1);
    check_eq("w8_pendA_tick5", pendA_w[I_W8], 1);
    step();
    check_eq("w8_miss_sticky", miss_w[I_W8], 1);
    check_eq("def_miss_none", miss_w[I_DEF], 0);
    tick = 1'b0;
    step();
    check_eq("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
